// File: rtl/unsigned_restoring_div_16by8.sv
// Sequential unsigned restoring divider: 2*DW-bit dividend / DW-bit divisor.
// Produces one quotient bit per clock behind a valid/ready handshake on each side.
//
// Ports:
//   clk, rst            rising-edge clock, async active-high reset
//   in_valid, in_ready  operand handshake (dividend, divisor)
//   out_valid, out_ready result handshake (quotient, remainder, div_by_zero)
module unsigned_restoring_div_16by8 #(
    parameter int DW = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2*DW-1:0] dividend,
    input  logic [DW-1:0]   divisor,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [2*DW-1:0] quotient,
    output logic [DW-1:0]   remainder,
    output logic            div_by_zero
);

    localparam int CW = $clog2(2 * DW);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [DW:0]     r_q, r_d;
    logic [2*DW-1:0] q_q, q_d;
    logic [DW-1:0]   dvs_q, dvs_d;
    logic [2*DW-1:0] quo_q, quo_d;
    logic [DW-1:0]   rem_q, rem_d;
    logic            dbz_q, dbz_d;
    logic            ov_q, ov_d;

    logic [DW:0]     r_shift;
    logic [DW:0]     r_sub;
    logic            q_bit;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            r_q     <= '0;
            q_q     <= '0;
            dvs_q   <= '0;
            quo_q   <= '0;
            rem_q   <= '0;
            dbz_q   <= 1'b0;
            ov_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            r_q     <= r_d;
            q_q     <= q_d;
            dvs_q   <= dvs_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
            dbz_q   <= dbz_d;
            ov_q    <= ov_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        r_d     = r_q;
        q_d     = q_q;
        dvs_d   = dvs_q;
        quo_d   = quo_q;
        rem_d   = rem_q;
        dbz_d   = dbz_q;
        ov_d    = ov_q;
        // Shift the next dividend bit into the partial remainder, then trial-subtract.
        r_shift = {r_q[DW-1:0], q_q[2*DW-1]};
        r_sub   = r_shift - {1'b0, dvs_q};
        q_bit   = (r_shift >= {1'b0, dvs_q});

        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    dvs_d = divisor;
                    dbz_d = 1'b0;
                    if (divisor == '0) begin
                        state_d = DONE;
                        quo_d   = '1;
                        rem_d   = dividend[DW-1:0];
                        dbz_d   = 1'b1;
                        ov_d    = 1'b1;
                    end else begin
                        state_d = CALC;
                        r_d     = '0;
                        q_d     = dividend;
                        cnt_d   = CW'(2 * DW - 1);
                    end
                end
            end
            CALC: begin
                r_d = q_bit ? r_sub : r_shift;
                q_d = {q_q[2*DW-2:0], q_bit};
                if (cnt_q == '0) begin
                    state_d = DONE;
                    quo_d   = q_d;
                    // Restored remainder is always below the divisor, so the MSB is zero.
                    rem_d   = r_d[DW-1:0];
                    ov_d    = 1'b1;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                    ov_d    = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign in_ready    = (state_q == IDLE);
    assign out_valid   = ov_q;
    assign quotient    = quo_q;
    assign remainder   = rem_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_unsigned_restoring_div_16by8.sv
// Self-checking bench for unsigned_restoring_div_16by8: directed cases,
// backpressure, mid-operation reset and random operands against plain arithmetic.
module tb_unsigned_restoring_div_16by8;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] dividend;
    logic [7:0]  divisor;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] quotient;
    logic [7:0]  remainder;
    logic        div_by_zero;

    int tests;
    int fails;

    unsigned_restoring_div_16by8 #(.DW(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .dividend   (dividend),
        .divisor    (divisor),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .quotient   (quotient),
        .remainder  (remainder),
        .div_by_zero(div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Entered and left on a falling edge. hold = cycles of out_ready=0 after out_valid.
    task automatic run_op(input logic [15:0] a, input logic [7:0] b, input int hold);
        logic [15:0] eq;
        logic [7:0]  er;
        int          lat;
        bit          seen;
        eq = (b == 8'd0) ? 16'hFFFF : a / {8'd0, b};
        er = (b == 8'd0) ? a[7:0] : 8'(a % {8'd0, b});
        check("rdy_before_accept", {31'd0, in_ready}, 32'd1);
        in_valid = 1'b1;
        dividend = a;
        divisor  = b;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        dividend = 16'($urandom);
        divisor  = 8'($urandom);
        lat  = 0;
        seen = 1'b0;
        for (int i = 1; i <= 40 && !seen; i++) begin
            @(negedge clk);
            if (out_valid) begin
                seen = 1'b1;
                lat  = i;
            end
        end
        check("latency", 32'(lat), (b == 8'd0) ? 32'd1 : 32'd17);
        if (!seen) return;
        check("quotient", {16'd0, quotient}, {16'd0, eq});
        check("remainder", {24'd0, remainder}, {24'd0, er});
        check("div_by_zero", {31'd0, div_by_zero}, {31'd0, (b == 8'd0)});
        if (b != 8'd0) begin
            check("q*d+r==a", 32'(quotient) * 32'(b) + 32'(remainder), {16'd0, a});
            check("r<d", {31'd0, (remainder < b)}, 32'd1);
        end
        for (int i = 0; i < hold; i++) begin
            in_valid = 1'b1;
            dividend = ~a;
            divisor  = b + 8'd1;
            @(negedge clk);
            check("hold_valid", {31'd0, out_valid}, 32'd1);
            check("hold_ready", {31'd0, in_ready}, 32'd0);
            check("hold_quo", {16'd0, quotient}, {16'd0, eq});
            check("hold_rem", {24'd0, remainder}, {24'd0, er});
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        @(negedge clk);
        check("post_valid", {31'd0, out_valid}, 32'd0);
        check("post_ready", {31'd0, in_ready}, 32'd1);
        if (hold > 0) begin
            @(negedge clk);
            check("no_stray_accept", {31'd0, in_ready}, 32'd1);
        end
    endtask

    initial begin
        tests     = 0;
        fails     = 0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        dividend  = '0;
        divisor   = '0;
        #12;
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_quotient", {16'd0, quotient}, 32'd0);
        check("rst_remainder", {24'd0, remainder}, 32'd0);
        check("rst_dbz", {31'd0, div_by_zero}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        run_op(16'h3039, 8'h7B, 0);
        check("dir_3039_q", {16'd0, quotient}, 32'h0064);
        run_op(16'hFFFF, 8'h01, 0);
        run_op(16'hFFFF, 8'hFF, 0);
        check("dir_ffff_ff_q", {16'd0, quotient}, 32'h0101);
        run_op(16'h1234, 8'h00, 0);
        check("dir_dbz_rem", {24'd0, remainder}, 32'h34);
        run_op(16'h0064, 8'h07, 10);
        check("dir_bp_q", {16'd0, quotient}, 32'h000E);
        check("dir_bp_dbz", {31'd0, div_by_zero}, 32'd0);

        // Reset five cycles into a calculation.
        in_valid = 1'b1;
        dividend = 16'h4321;
        divisor  = 8'h0D;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (5) @(negedge clk);
        check("calc_busy", {31'd0, in_ready}, 32'd0);
        #2;
        rst = 1'b1;
        #1;
        check("mid_rst_valid", {31'd0, out_valid}, 32'd0);
        check("mid_rst_ready", {31'd0, in_ready}, 32'd1);
        check("mid_rst_quo", {16'd0, quotient}, 32'd0);
        check("mid_rst_rem", {24'd0, remainder}, 32'd0);
        check("mid_rst_dbz", {31'd0, div_by_zero}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        run_op(16'h0000, 8'h05, 0);

        for (int n = 0; n < 2000; n++) begin
            run_op(16'($urandom), 8'($urandom_range(1, 255)), 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
